// File: rtl/triangle_fetch.sv
// rtl/triangle_fetch.sv - walks the triangle RAM and presents one record per valid/ready transfer
module triangle_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_TRI    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_finish,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data1,
    input  logic [DATA_WIDTH-1:0] ram_read_data2,
    input  logic [DATA_WIDTH-1:0] ram_read_data3,
    input  logic [DATA_WIDTH-1:0] ram_read_data4,
    input  logic [DATA_WIDTH-1:0] ram_read_data5,
    input  logic [DATA_WIDTH-1:0] ram_read_data6,
    input  logic [DATA_WIDTH-1:0] ram_read_data7,
    input  logic [DATA_WIDTH-1:0] ram_read_data8,
    input  logic [DATA_WIDTH-1:0] ram_read_data9,
    output logic [DATA_WIDTH-1:0] tri_x0,
    output logic [DATA_WIDTH-1:0] tri_y0,
    output logic [DATA_WIDTH-1:0] tri_x1,
    output logic [DATA_WIDTH-1:0] tri_y1,
    output logic [DATA_WIDTH-1:0] tri_x2,
    output logic [DATA_WIDTH-1:0] tri_y2,
    output logic [DATA_WIDTH-1:0] tri_color,
    output logic [7:0]            tri_index,
    output logic                  tri_valid,
    input  logic                  tri_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_LOAD = 3'd1;
    localparam logic [2:0] S_HDR_ADDR  = 3'd2;
    localparam logic [2:0] S_HDR_CAP   = 3'd3;
    localparam logic [2:0] S_REC_ADDR  = 3'd4;
    localparam logic [2:0] S_REC_CAP   = 3'd5;
    localparam logic [2:0] S_PRESENT   = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [7:0]            MAX_TRI_C  = 8'(MAX_TRI);
    localparam logic [ADDR_WIDTH-1:0] REC_FIRST  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] REC_STRIDE = ADDR_WIDTH'(9);

    logic [2:0]            state_q, state_d;
    logic [7:0]            k_q, k_d;
    logic [7:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0] rec_addr_q, rec_addr_d;
    logic [DATA_WIDTH-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [DATA_WIDTH-1:0] x2_q, x2_d, y2_q, y2_d, color_q, color_d;
    logic [7:0]            index_q, index_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [7:0] hdr_n;
    logic [7:0] eff_count;
    logic [7:0] k_next;
    logic       unused_words;

    // Words 8 and 9 of each record are padding in the RAM layout.
    assign unused_words = ^{ram_read_data8, ram_read_data9};

    assign hdr_n     = ram_read_data1[7:0];
    assign eff_count = (hdr_n > MAX_TRI_C) ? MAX_TRI_C : hdr_n;
    assign k_next    = k_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        count_d    = count_q;
        rec_addr_d = rec_addr_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        x2_d       = x2_q;
        y2_d       = y2_q;
        color_d    = color_q;
        index_d    = index_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WAIT_LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_WAIT_LOAD: begin
                if (load_finish) state_d = S_HDR_ADDR;
            end
            S_HDR_ADDR: state_d = S_HDR_CAP;
            S_HDR_CAP: begin
                count_d    = eff_count;
                k_d        = 8'd0;
                rec_addr_d = REC_FIRST;
                if (eff_count == 8'd0) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_REC_ADDR;
                end
            end
            S_REC_ADDR: state_d = S_REC_CAP;
            S_REC_CAP: begin
                x0_d    = ram_read_data1;
                y0_d    = ram_read_data2;
                x1_d    = ram_read_data3;
                y1_d    = ram_read_data4;
                x2_d    = ram_read_data5;
                y2_d    = ram_read_data6;
                color_d = ram_read_data7;
                index_d = k_q;
                valid_d = 1'b1;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (tri_ready) begin
                    valid_d    = 1'b0;
                    k_d        = k_next;
                    rec_addr_d = rec_addr_q + REC_STRIDE;
                    if (k_next < count_q) begin
                        state_d = S_REC_ADDR;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            count_q    <= '0;
            rec_addr_q <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            color_q    <= '0;
            index_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            count_q    <= count_d;
            rec_addr_q <= rec_addr_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            color_q    <= color_d;
            index_q    <= index_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Header reads use address 0, which is also the idle value.
    assign ram_read_addr = (state_q == S_REC_ADDR || state_q == S_REC_CAP) ? rec_addr_q : '0;

    assign tri_x0    = x0_q;
    assign tri_y0    = y0_q;
    assign tri_x1    = x1_q;
    assign tri_y1    = y1_q;
    assign tri_x2    = x2_q;
    assign tri_y2    = y2_q;
    assign tri_color = color_q;
    assign tri_index = index_q;
    assign tri_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_triangle_fetch.sv
// tb/tb_triangle_fetch.sv - table-driven scoreboard bench for triangle_fetch
module tb_triangle_fetch;

    logic        clk = 1'b0;
    logic        reset, start, load_finish, tri_ready;
    logic [7:0]  ram_read_addr;
    logic [31:0] d1, d2, d3, d4, d5, d6, d7, d8, d9;
    logic [31:0] tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2, tri_color;
    logic [7:0]  tri_index;
    logic        tri_valid, busy, done;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    always_comb begin
        d1 = mem[ram_read_addr];
        d2 = mem[ram_read_addr + 8'd1];
        d3 = mem[ram_read_addr + 8'd2];
        d4 = mem[ram_read_addr + 8'd3];
        d5 = mem[ram_read_addr + 8'd4];
        d6 = mem[ram_read_addr + 8'd5];
        d7 = mem[ram_read_addr + 8'd6];
        d8 = mem[ram_read_addr + 8'd7];
        d9 = mem[ram_read_addr + 8'd8];
    end

    triangle_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_TRI(2)) dut (
        .clk(clk), .reset(reset), .start(start), .load_finish(load_finish),
        .ram_read_addr(ram_read_addr),
        .ram_read_data1(d1), .ram_read_data2(d2), .ram_read_data3(d3),
        .ram_read_data4(d4), .ram_read_data5(d5), .ram_read_data6(d6),
        .ram_read_data7(d7), .ram_read_data8(d8), .ram_read_data9(d9),
        .tri_x0(tri_x0), .tri_y0(tri_y0), .tri_x1(tri_x1), .tri_y1(tri_y1),
        .tri_x2(tri_x2), .tri_y2(tri_y2), .tri_color(tri_color),
        .tri_index(tri_index), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .busy(busy), .done(done)
    );

    typedef struct {
        int n; int stall; int lf_delay; bit lf_drop; bit restart;
        int exp_xfers; int exp_first; int exp_done;
    } vec_t;

    typedef struct packed {
        logic [7:0]       idx;
        logic [6:0][31:0] f;
    } rec_t;

    int   checks = 0;
    int   failures = 0;
    rec_t q_exp[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fval(input int k, input int w, input int salt);
        logic [31:0] v;
        v = (k == 0 && w == 6) ? 32'hFF : 32'(k * 7 + w + ((k == 0) ? 1 : 0));
        return v + 32'(salt << 20);
    endfunction

    function automatic rec_t dut_rec();
        rec_t r;
        r.idx = tri_index;
        r.f[0] = tri_x0; r.f[1] = tri_y0; r.f[2] = tri_x1; r.f[3] = tri_y1;
        r.f[4] = tri_x2; r.f[5] = tri_y2; r.f[6] = tri_color;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int   eff, first, done_cyc, xfers, stall_left, stall_cycles;
        int   addr_bad, busy_bad, hold_bad, seen_mask, a;
        bit   held_ok;
        rec_t e, got, held, last;
        eff = (v.n > 2) ? 2 : v.n;
        first = -1; done_cyc = -1; xfers = 0; stall_left = v.stall; stall_cycles = 0;
        addr_bad = 0; busy_bad = 0; hold_bad = 0; seen_mask = 0; held_ok = 1'b0;
        last = '0;
        mem[0] = 32'(v.n);
        for (int k = 0; k < 4; k++)
            for (int w = 0; w < 9; w++)
                mem[1 + 9 * k + w] = (w < 7) ? fval(k, w, id) : (32'hDEAD0000 | 32'(k));
        q_exp.delete();
        for (int k = 0; k < eff; k++) begin
            e.idx = 8'(k);
            for (int w = 0; w < 7; w++) e.f[w] = fval(k, w, id);
            q_exp.push_back(e);
        end
        @(negedge clk);
        start = 1'b1;
        tri_ready = (v.stall == 0);
        load_finish = (v.lf_delay == 0);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = (v.restart && cyc == 3);
            load_finish = (cyc >= 1 + v.lf_delay) && !(v.lf_drop && cyc >= 3 + v.lf_delay);
            a = int'(ram_read_addr);
            if (a != 0) begin
                if (cyc < 4 + v.lf_delay || (a - 1) % 9 != 0 || (a - 1) / 9 >= eff) addr_bad++;
                else seen_mask |= (1 << ((a - 1) / 9));
            end
            if (cyc < v.exp_done) begin
                if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
            end else if (busy !== 1'b0 || done !== 1'b1 || tri_valid !== 1'b0) busy_bad++;
            if (tri_valid && first < 0) first = cyc;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (tri_valid && stall_left > 0) begin
                tri_ready = 1'b0;
                stall_left--;
            end else begin
                tri_ready = 1'b1;
            end
            if (tri_valid && !tri_ready) begin
                stall_cycles++;
                if (held_ok && dut_rec() !== held) hold_bad++;
                held = dut_rec();
                held_ok = 1'b1;
            end
            if (tri_valid && tri_ready) begin
                xfers++;
                got = dut_rec();
                if (held_ok && got !== held) hold_bad++;
                held_ok = 1'b0;
                if (q_exp.size() == 0) begin
                    check($sformatf("r%0d_extra_xfer", id), 64'(xfers), 64'(eff));
                end else begin
                    e = q_exp.pop_front();
                    last = e;
                    check($sformatf("r%0d_idx", id), 64'(got.idx), 64'(e.idx));
                    for (int w = 0; w < 7; w++)
                        check($sformatf("r%0d_k%0d_f%0d", id, e.idx, w), 64'(got.f[w]), 64'(e.f[w]));
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        check($sformatf("r%0d_done_cycle", id), 64'(done_cyc), 64'(v.exp_done));
        check($sformatf("r%0d_first_valid", id), 64'(first), 64'(v.exp_first));
        check($sformatf("r%0d_xfers", id), 64'(xfers), 64'(v.exp_xfers));
        check($sformatf("r%0d_sb_left", id), 64'(q_exp.size()), 64'd0);
        check($sformatf("r%0d_addr_bad", id), 64'(addr_bad), 64'd0);
        check($sformatf("r%0d_addr_seen", id), 64'(seen_mask), 64'((1 << eff) - 1));
        check($sformatf("r%0d_busy_done_bad", id), 64'(busy_bad), 64'd0);
        check($sformatf("r%0d_stall_cycles", id), 64'(stall_cycles), 64'(v.stall));
        check($sformatf("r%0d_hold_bad", id), 64'(hold_bad), 64'd0);
        if (eff > 0) begin
            check($sformatf("r%0d_retain_x0", id), 64'(tri_x0), 64'(last.f[0]));
            check($sformatf("r%0d_retain_color", id), 64'(tri_color), 64'(last.f[6]));
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{n: 2,   stall: 0, lf_delay: 0,  lf_drop: 0, restart: 0, exp_xfers: 2, exp_first: 6,  exp_done: 10};
        vecs[1] = '{n: 2,   stall: 5, lf_delay: 0,  lf_drop: 0, restart: 1, exp_xfers: 2, exp_first: 6,  exp_done: 15};
        vecs[2] = '{n: 0,   stall: 0, lf_delay: 0,  lf_drop: 0, restart: 0, exp_xfers: 0, exp_first: -1, exp_done: 4};
        vecs[3] = '{n: 200, stall: 0, lf_delay: 0,  lf_drop: 0, restart: 0, exp_xfers: 2, exp_first: 6,  exp_done: 10};
        vecs[4] = '{n: 2,   stall: 0, lf_delay: 20, lf_drop: 1, restart: 0, exp_xfers: 2, exp_first: 26, exp_done: 30};
        vecs[5] = '{n: 1,   stall: 0, lf_delay: 0,  lf_drop: 0, restart: 0, exp_xfers: 1, exp_first: 6,  exp_done: 7};
        vecs[6] = '{n: 3,   stall: 2, lf_delay: 0,  lf_drop: 0, restart: 0, exp_xfers: 2, exp_first: 6,  exp_done: 12};

        for (int i = 0; i < 256; i++) mem[i] = 32'(i) ^ 32'h5A5A0000;
        reset = 1'b0; start = 1'b0; load_finish = 1'b0; tri_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(tri_valid), 64'd0);
        check("reset_busy_done", 64'({busy, done}), 64'd0);
        check("reset_addr", 64'(ram_read_addr), 64'd0);
        check("reset_rec", 64'(tri_x0 | tri_color | 32'(tri_index)), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Abort a pass while a record is presented and stalled.
        mem[0] = 32'd2;
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 7; w++) mem[1 + 9 * k + w] = fval(k, w, 9);
        @(negedge clk);
        start = 1'b1; load_finish = 1'b1; tri_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !tri_valid; i++) @(negedge clk);
        check("abort_valid_seen", 64'(tri_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_valid", 64'(tri_valid), 64'd0);
        check("abort_busy_done", 64'({busy, done}), 64'd0);
        check("abort_rec", 64'(tri_x0 | tri_y2 | tri_color), 64'd0);
        check("abort_index_addr", 64'({tri_index, ram_read_addr}), 64'd0);
        tri_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_abort_idle", 64'({busy, done, tri_valid}), 64'd0);
        check("post_abort_addr", 64'(ram_read_addr), 64'd0);
        run_vec(vecs[0], 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
